// File: rtl/wb_interconnect.sv
// Wishbone single-master, NS-slave interconnect.
// Decodes a page field to one slave, allows one outstanding transaction,
// times out slaves that never ack, and logs errors by cause with a
// saturating error counter.
module wb_interconnect #(
  parameter int NS        = 3,
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int PAGE_BITS = 8,
  parameter logic [AW-PAGE_BITS-1:0] BASE_PAGE = 22'h081,
  parameter int TIMEOUT   = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [DW-1:0]      i_wb_data,
  input  logic [DW/8-1:0]    i_wb_sel,
  output logic               o_wb_stall,
  output logic               o_wb_ack,
  output logic               o_wb_err,
  output logic [DW-1:0]      o_wb_data,
  output logic [NS-1:0]      o_s_stb,
  output logic               o_s_we,
  output logic [AW-1:0]      o_s_addr,
  output logic [DW-1:0]      o_s_data,
  output logic [DW/8-1:0]    o_s_sel,
  input  logic [NS-1:0]      i_s_stall,
  input  logic [NS-1:0]      i_s_ack,
  input  logic [NS*DW-1:0]   i_s_data,
  input  logic               i_err_clr,
  output logic [AW-1:0]      o_err_addr,
  output logic [1:0]         o_err_cause,
  output logic [15:0]        o_err_count
);

  localparam int PW = AW - PAGE_BITS;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   page;
  logic [NS-1:0]   hit;
  logic [IW-1:0]   hit_idx;
  logic            none_sel;
  logic [DW-1:0]   s_rdata [NS];

  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   addr_q;
  logic [TW-1:0]   tcnt_q;
  logic            resp_ack_q;
  logic            resp_err_q;

  logic            idle_stall;
  logic            accept;
  logic            go_ack;
  logic            go_err;
  logic [1:0]      cause_nx;
  logic [AW-1:0]   req_addr;

  // The shared slave bus is a straight copy of the master request.
  assign o_s_we   = i_wb_we;
  assign o_s_addr = i_wb_addr;
  assign o_s_data = i_wb_data;
  assign o_s_sel  = i_wb_sel;

  assign page     = i_wb_addr[AW-1:PAGE_BITS];
  assign none_sel = ~|hit;
  // Unmapped errors log the address being accepted this cycle; timeouts log the latched one.
  assign req_addr = accept ? i_wb_addr : addr_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // Page decode to a one-hot hit vector and its index; unpack slave read data.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int k = 0; k < NS; k++) begin
      s_rdata[k] = i_s_data[k*DW +: DW];
      if (page == BASE_PAGE + PW'(k)) begin
        hit[k]  = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  // Next-state and master/slave handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nx   = state;
    o_s_stb    = '0;
    o_wb_stall = 1'b1;
    o_wb_ack   = 1'b0;
    o_wb_err   = 1'b0;
    idle_stall = |(hit & i_s_stall);
    accept     = 1'b0;
    go_ack     = 1'b0;
    go_err     = 1'b0;
    cause_nx   = 2'b00;
    case (state)
      IDLE: begin
        o_s_stb    = (i_wb_cyc && i_wb_stb) ? hit : '0;
        o_wb_stall = idle_stall;
        if (i_wb_cyc && i_wb_stb && !idle_stall) begin
          accept = 1'b1;
          if (none_sel) begin
            state_nx = RESP;
            go_err   = 1'b1;
            cause_nx = CAUSE_UNMAPPED;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        // A dropped cycle aborts silently; an ack in the last cycle beats the timeout.
        if (!i_wb_cyc) begin
          state_nx = IDLE;
        end else if (i_s_ack[idx_q]) begin
          state_nx = RESP;
          go_ack   = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_nx = RESP;
          go_err   = 1'b1;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      RESP: begin
        o_wb_ack = resp_ack_q & i_wb_cyc;
        o_wb_err = resp_err_q & i_wb_cyc;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, timeout counter, response flags and read data capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idx_q      <= '0;
      addr_q     <= '0;
      tcnt_q     <= '0;
      resp_ack_q <= 1'b0;
      resp_err_q <= 1'b0;
      o_wb_data  <= '0;
    end else begin
      if (accept) begin
        idx_q  <= hit_idx;
        addr_q <= i_wb_addr;
      end
      if (accept)             tcnt_q <= '0;
      else if (state == BUSY) tcnt_q <= tcnt_q + TW'(1);
      resp_ack_q <= go_ack;
      resp_err_q <= go_err;
      if (go_ack) o_wb_data <= s_rdata[idx_q];
    end
  end

  // Error capture and saturating error counter; a clear coinciding with an error leaves 1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_addr  <= '0;
      o_err_cause <= 2'b00;
      o_err_count <= 16'd0;
    end else begin
      if (go_err) begin
        o_err_addr  <= req_addr;
        o_err_cause <= cause_nx;
      end
      if (i_err_clr)
        o_err_count <= go_err ? 16'd1 : 16'd0;
      else if (go_err && o_err_count != 16'hFFFF)
        o_err_count <= o_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin the key scenarios.
module tb_wb_interconnect;

  localparam int NS        = 3;
  localparam int AW        = 30;
  localparam int DW        = 32;
  localparam int PAGE_BITS = 8;
  localparam int BASE      = 'h081;
  localparam int TIMEOUT   = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic [DW-1:0]     wdata = '0;
  logic [DW/8-1:0]   sel = '0;
  logic [NS-1:0]     s_stall = '0, s_ack = '0;
  logic [NS*DW-1:0]  s_data = '0;
  logic              err_clr = 1'b0;

  logic              o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]     o_wb_data;
  logic [NS-1:0]     o_s_stb;
  logic              o_s_we;
  logic [AW-1:0]     o_s_addr;
  logic [DW-1:0]     o_s_data;
  logic [DW/8-1:0]   o_s_sel;
  logic [AW-1:0]     o_err_addr;
  logic [1:0]        o_err_cause;
  logic [15:0]       o_err_count;

  int total = 0;
  int bad   = 0;

  wb_interconnect #(
    .NS(NS), .AW(AW), .DW(DW), .PAGE_BITS(PAGE_BITS),
    .BASE_PAGE(22'h081), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_wb_data(o_wb_data),
    .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_addr(o_s_addr),
    .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_data),
    .i_err_clr(err_clr),
    .o_err_addr(o_err_addr), .o_err_cause(o_err_cause), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int unsigned   cyc_n = 0;
  logic          m_pend = 1'b0;   // a request is waiting on its slave
  logic          m_rack = 1'b0;   // response cycle carrying an ack
  logic          m_rerr = 1'b0;   // response cycle carrying an error
  int            m_idx = 0;
  int unsigned   m_acc = 0;       // cycle number of acceptance
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] m_eaddr = '0;
  logic [1:0]    m_cause = 2'b00;
  logic [15:0]   m_cnt = 16'd0;
  int            preload_cnt = 0;
  int            seen_preload = 0;

  // Slave index for an address, or -1 when no slave owns its page.
  function automatic int slave_of(input logic [AW-1:0] a);
    int p;
    p = int'(a >> PAGE_BITS);
    if (p >= BASE && p < BASE + NS) return p - BASE;
    return -1;
  endfunction

  function automatic logic model_stall();
    int k;
    if (m_pend || m_rack || m_rerr) return 1'b1;
    k = slave_of(addr);
    if (k < 0) return 1'b0;
    return s_stall[k];
  endfunction

  // Advance the model on each clock edge from the inputs seen during the ending cycle.
  always @(posedge clk or posedge rst) begin
    logic       log_err;
    logic [1:0] cause;
    int         k;
    if (rst) begin
      m_pend = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
      m_data = '0; m_eaddr = '0; m_cause = 2'b00; m_cnt = 16'd0;
      cyc_n = 0;
    end else begin
      log_err = 1'b0;
      cause   = 2'b00;
      if (seen_preload != preload_cnt) begin
        seen_preload = preload_cnt;
        m_cnt = 16'hFFFE;
      end
      if (m_rack || m_rerr) begin
        m_rack = 1'b0;
        m_rerr = 1'b0;
      end else if (m_pend) begin
        if (!cyc) begin
          m_pend = 1'b0;
        end else if (s_ack[m_idx]) begin
          m_data = s_data[m_idx*DW +: DW];
          m_pend = 1'b0;
          m_rack = 1'b1;
        end else if (cyc_n == m_acc + TIMEOUT) begin
          m_pend  = 1'b0;
          m_rerr  = 1'b1;
          log_err = 1'b1;
          cause   = 2'b10;
        end
      end else if (cyc && stb && !model_stall()) begin
        k = slave_of(addr);
        m_addr = addr;
        if (k < 0) begin
          m_rerr  = 1'b1;
          log_err = 1'b1;
          cause   = 2'b01;
        end else begin
          m_pend = 1'b1;
          m_idx  = k;
          m_acc  = cyc_n;
        end
      end
      if (log_err) begin
        m_eaddr = m_addr;
        m_cause = cause;
      end
      if (err_clr)                          m_cnt = log_err ? 16'd1 : 16'd0;
      else if (log_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      cyc_n++;
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  logic [NS-1:0] exp_stb;
  int            cmp_k;
  always @(negedge clk) begin
    if (!rst) begin
      cmp_k   = slave_of(addr);
      exp_stb = '0;
      if (!(m_pend || m_rack || m_rerr) && cyc && stb && cmp_k >= 0) exp_stb[cmp_k] = 1'b1;
      check("m_stall", o_wb_stall, model_stall());
      check("m_s_stb", o_s_stb, exp_stb);
      check("m_ack", o_wb_ack, m_rack & cyc);
      check("m_err", o_wb_err, m_rerr & cyc);
      check("m_rdata", o_wb_data, m_data);
      check("m_err_addr", o_err_addr, m_eaddr);
      check("m_err_cause", o_err_cause, m_cause);
      check("m_err_count", o_err_count, m_cnt);
      check("m_s_addr", o_s_addr, addr);
      check("m_s_we", o_s_we, we);
      check("m_s_data", o_s_data, wdata);
      check("m_s_sel", o_s_sel, sel);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unmapped request to page 0x090; leaves the bench in the response cycle.
  task automatic unmapped_req(input logic clr);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h0000_9000; err_clr = clr;
    tick();
    stb = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    int acks;
    sel = 4'hF;
    tick();
    tick();
    check("rst_ack", o_wb_ack, 0);
    check("rst_err", o_wb_err, 0);
    check("rst_data", o_wb_data, 0);
    check("rst_err_count", o_err_count, 0);
    rst = 1'b0;
    tick();

    // Mapped read from slave 1; slave acks three cycles after acceptance.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h0000_8205;
    #1;
    check("rd_stb", o_s_stb, 3'b010);
    check("rd_stall", o_wb_stall, 0);
    tick(); stb = 1'b0;
    tick();
    tick(); s_ack = 3'b010; s_data[63:32] = 32'hDEAD_BEEF;
    tick(); s_ack = 3'b000;
    check("rd_ack", o_wb_ack, 1);
    check("rd_data", o_wb_data, 32'hDEAD_BEEF);
    check("rd_err", o_wb_err, 0);
    check("rd_err_count", o_err_count, 0);
    tick(); cyc = 1'b0;
    tick();

    // Write to slave 0 held off by its stall for five cycles.
    s_stall = 3'b001; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h0000_8110; wdata = 32'hCAFE_0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_stall", o_wb_stall, 1);
      tick();
    end
    s_stall = 3'b000;
    #1;
    check("st_accept_stall", o_wb_stall, 0);
    tick(); stb = 1'b0; s_ack = 3'b001;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_wb_ack) acks++;
      if (i == 2) s_ack = 3'b000;
      tick();
    end
    check("st_acks", acks, 1);
    cyc = 1'b0; we = 1'b0;
    tick();

    // Unmapped address.
    unmapped_req(1'b0);
    check("um_err", o_wb_err, 1);
    check("um_ack", o_wb_ack, 0);
    check("um_cause", o_err_cause, 2'b01);
    check("um_addr", o_err_addr, 30'h0000_9000);
    check("um_count", o_err_count, 1);
    tick(); cyc = 1'b0;
    tick();

    // Timeout: slave 2 never acks.
    cyc = 1'b1; stb = 1'b1; addr = 30'h0000_8300;
    tick(); stb = 1'b0;
    repeat (63) tick();
    check("to_not_yet", o_wb_err, 0);
    tick();
    check("to_err", o_wb_err, 1);
    check("to_cause", o_err_cause, 2'b10);
    check("to_addr", o_err_addr, 30'h0000_8300);
    check("to_count", o_err_count, 2);
    tick(); cyc = 1'b0;
    tick();

    // Ack in the last BUSY cycle beats the timeout.
    cyc = 1'b1; stb = 1'b1; addr = 30'h0000_8344;
    tick(); stb = 1'b0;
    repeat (63) tick();
    s_ack = 3'b100; s_data[95:64] = 32'h1234_5678;
    tick(); s_ack = 3'b000;
    check("tr_ack", o_wb_ack, 1);
    check("tr_err", o_wb_err, 0);
    check("tr_data", o_wb_data, 32'h1234_5678);
    check("tr_count", o_err_count, 2);
    tick(); cyc = 1'b0;
    tick();

    // Abort during BUSY, followed by a late ack that must be ignored.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h0000_8100;
    tick(); stb = 1'b0;
    tick(); cyc = 1'b0;
    tick();
    check("ab_ack", o_wb_ack, 0);
    check("ab_err", o_wb_err, 0);
    check("ab_stall", o_wb_stall, 0);
    s_ack = 3'b001; s_data[31:0] = 32'hBAD0_BAD0;
    tick(); s_ack = 3'b000;
    check("ab_late_ack", o_wb_ack, 0);
    check("ab_data", o_wb_data, 32'h1234_5678);
    check("ab_count", o_err_count, 2);
    we = 1'b0;
    tick();

    // Preload the counter to FFFE, then saturate it.
    @(negedge clk); #1;
    force dut.o_err_count = 16'hFFFE;
    preload_cnt++;
    #1;
    release dut.o_err_count;
    tick();
    for (int i = 0; i < 3; i++) begin
      unmapped_req(1'b0);
      tick(); cyc = 1'b0;
      tick();
    end
    check("sat_count", o_err_count, 16'hFFFF);

    // Clear coinciding with an error leaves a count of one.
    unmapped_req(1'b1);
    check("clr_err_count", o_err_count, 1);
    tick(); cyc = 1'b0;
    tick();

    // Clear alone zeroes the count but keeps the captured address and cause.
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    check("clr_count", o_err_count, 0);
    check("clr_addr_kept", o_err_addr, 30'h0000_9000);
    check("clr_cause_kept", o_err_cause, 2'b01);

    // Page below the first slave is unmapped too.
    cyc = 1'b1; stb = 1'b1; addr = 30'h0000_7F10;
    tick(); stb = 1'b0;
    check("lo_err", o_wb_err, 1);
    check("lo_addr", o_err_addr, 30'h0000_7F10);
    check("lo_count", o_err_count, 1);
    tick(); cyc = 1'b0;
    tick();

    // Asynchronous reset in the middle of a BUSY transaction.
    cyc = 1'b1; stb = 1'b1; addr = 30'h0000_8204;
    tick(); stb = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("ar_ack", o_wb_ack, 0);
    check("ar_err", o_wb_err, 0);
    check("ar_data", o_wb_data, 0);
    check("ar_err_addr", o_err_addr, 0);
    check("ar_err_cause", o_err_cause, 0);
    check("ar_err_count", o_err_count, 0);
    check("ar_stall", o_wb_stall, 0);
    tick(); cyc = 1'b0;
    rst = 1'b0;
    tick();

    // Recovery: write to slave 2 acked one cycle after acceptance.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h0000_8300; wdata = 32'h5555_AAAA;
    tick(); stb = 1'b0; s_ack = 3'b100; s_data[95:64] = 32'h0BAD_F00D;
    tick(); s_ack = 3'b000;
    check("rc_ack", o_wb_ack, 1);
    check("rc_data", o_wb_data, 32'h0BAD_F00D);
    tick(); cyc = 1'b0; we = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
